// File: rtl/mips_multi_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath strobes and selects for each step.
module mips_multi_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [3:0] state,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_e state_q, state_d;

    logic       iord_c, irwrite_c, memwrite_c, regdst_c, memtoreg_c;
    logic       regwrite_c, alusrca_c, pcen_c, done_c;
    logic [1:0] alusrcb_c, aluop_c, pcsrc_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        iord_c     = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        regdst_c   = 1'b0;
        memtoreg_c = 1'b0;
        regwrite_c = 1'b0;
        alusrca_c  = 1'b0;
        pcen_c     = 1'b0;
        done_c     = 1'b0;
        alusrcb_c  = 2'b00;
        aluop_c    = 2'b00;
        pcsrc_c    = 2'b00;
        case (state_q)
            S_FETCH: begin
                alusrcb_c = 2'b01;
                irwrite_c = mem_ready;
                pcen_c    = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb_c = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    // Unknown opcodes retire here as a NOP.
                    default: begin
                        state_d = S_FETCH;
                        done_c  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord_c  = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                done_c     = 1'b1;
            end
            S_MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                done_c     = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca_c = 1'b1;
                aluop_c   = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
                done_c     = 1'b1;
            end
            S_BRANCH: begin
                alusrca_c = 1'b1;
                aluop_c   = 2'b01;
                pcsrc_c   = 2'b01;
                pcen_c    = zero;
                done_c    = 1'b1;
            end
            S_ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                done_c     = 1'b1;
            end
            S_JUMP: begin
                pcsrc_c = 2'b10;
                pcen_c  = 1'b1;
                done_c  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset forces FETCH, but FETCH itself drives nonzero selects; gate
    // everything so the datapath sees all-zero controls while rst_n is low.
    assign IorD       = rst_n & iord_c;
    assign IRWrite    = rst_n & irwrite_c;
    assign MemWrite   = rst_n & memwrite_c;
    assign RegDst     = rst_n & regdst_c;
    assign MemtoReg   = rst_n & memtoreg_c;
    assign RegWrite   = rst_n & regwrite_c;
    assign ALUSrcA    = rst_n & alusrca_c;
    assign PCEn       = rst_n & pcen_c;
    assign instr_done = rst_n & done_c;
    assign ALUSrcB    = rst_n ? alusrcb_c : 2'b00;
    assign ALUOp      = rst_n ? aluop_c   : 2'b00;
    assign PCSrc      = rst_n ? pcsrc_c   : 2'b00;
    assign state      = state_q;

endmodule
